// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

    typedef enum logic {BOOT, RUN} state_t;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/ifetch_next_pc.sv
// Next-PC priority mux: JR > J/JAL > taken branch > pc+4.
module ifetch_next_pc
    import ifetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_d4,
    input  logic        i_if_valid,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic [1:0]  i_jump,
    input  logic [25:0] i_jump_index,
    input  logic [31:0] i_jr_addr,
    output logic        o_redirect,
    output logic [31:0] o_next_pc,
    output logic        o_misalign
);

    always_comb begin
        o_redirect = 1'b0;
        o_next_pc  = i_pc + INSTR_BYTES;
        // Redirect sources are only trusted when decode holds a real instruction
        if (i_if_valid) begin
            priority case (1'b1)
                (i_jump == JMP_JR): begin
                    o_redirect = 1'b1;
                    o_next_pc  = i_jr_addr;
                end
                (i_jump == JMP_J): begin
                    o_redirect = 1'b1;
                    o_next_pc  = {i_pc_d4[31:28], i_jump_index, 2'b00};
                end
                i_branch_taken: begin
                    o_redirect = 1'b1;
                    o_next_pc  = i_branch_target;
                end
                default: ;
            endcase
        end
        o_misalign = o_redirect && (o_next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/ifetch_stage.sv
// MIPS fetch stage: PC, next-PC select, IF/ID register.
// Optional misaligned-redirect trap: IFETCH_MISALIGN_TRAP_EN.
module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [1:0]  jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic        fetch_exc,
    output logic [31:0] bad_addr
);

    localparam int AW = $clog2(IMEM_BYTES);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;
    logic        r_if_valid;

    logic        w_redirect;
    logic [31:0] w_next_pc;
    logic        w_misalign;
    logic [31:0] w_pc4;

    assign w_pc4     = r_pc + INSTR_BYTES;
    assign imem_addr = {{(32-AW){1'b0}}, r_pc[AW-1:0]};
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign if_pc4    = r_if_pc4;
    assign if_valid  = r_if_valid;

    ifetch_next_pc u_next_pc (
        .i_pc            (r_pc),
        .i_pc_d4         (r_if_pc4),
        .i_if_valid      (r_if_valid),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_index    (jump_index),
        .i_jr_addr       (jr_addr),
        .o_redirect      (w_redirect),
        .o_next_pc       (w_next_pc),
        .o_misalign      (w_misalign)
    );

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        r_fetch_exc;
    logic [31:0] r_bad_addr;
    assign fetch_exc = r_fetch_exc;
    assign bad_addr  = r_bad_addr;
`else
    logic w_unused;
    assign w_unused  = ^{w_misalign, EXC_VECTOR};
    assign fetch_exc = 1'b0;
    assign bad_addr  = 32'h0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_if_instr <= 32'h0;
            r_if_pc    <= 32'h0;
            r_if_pc4   <= 32'h0;
            r_if_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            r_fetch_exc <= 1'b0;
            r_bad_addr  <= 32'h0;
`endif
        end else begin
`ifdef IFETCH_MISALIGN_TRAP_EN
            r_fetch_exc <= 1'b0;
`endif
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (w_redirect) begin
                        r_if_valid <= 1'b0;
                        r_if_instr <= 32'h0;
`ifdef IFETCH_MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            r_pc        <= EXC_VECTOR;
                            r_fetch_exc <= 1'b1;
                            r_bad_addr  <= w_next_pc;
                        end else begin
                            r_pc <= w_next_pc;
                        end
`else
                        r_pc <= {w_next_pc[31:2], 2'b00};
`endif
                    end else if (!stall) begin
                        r_pc       <= w_pc4;
                        r_if_instr <= imem_rdata;
                        r_if_pc    <= r_pc;
                        r_if_pc4   <= w_pc4;
                        r_if_valid <= 1'b1;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage.
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [1:0]  jump;
    logic [25:0] jump_index;
    logic [31:0] jr_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        fetch_exc;
    logic [31:0] bad_addr;

    int n_cmp = 0;
    int n_err = 0;

    // Instruction word tags its own address so captures are traceable.
    assign imem_rdata = 32'hA500_0000 | imem_addr;

    always #5 clk = ~clk;

    ifetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr_addr       (jr_addr),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc4        (if_pc4),
        .if_valid      (if_valid),
        .fetch_exc     (fetch_exc),
        .bad_addr      (bad_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        stall = 0; branch_taken = 0; branch_target = 0;
        jump = 2'b00; jump_index = 0; jr_addr = 0;
    endtask

    task automatic test_reset();
        clear_redirect();
        rst_n = 0;
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", if_valid); end
        n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h exp 0", if_pc); end
        n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h exp 0", if_instr); end
        n_cmp++; if (fetch_exc !== 1'b0 || bad_addr !== 32'h0) begin n_err++; $display("FAIL rst_exc got %b/%h exp 0/0", fetch_exc, bad_addr); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        rst_n = 1;
    endtask

    task automatic test_boot_and_run();
        tick();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL boot got v=%b a=%h exp v=0 a=0", if_valid, imem_addr); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_err++; $display("FAIL first got v=%b pc=%h exp v=1 pc=0", if_valid, if_pc); end
        n_cmp++; if (if_instr !== 32'hA500_0000 || if_pc4 !== 32'h4) begin n_err++; $display("FAIL first_data got %h/%h exp a5000000/4", if_instr, if_pc4); end
        tick();
        n_cmp++; if (if_pc !== 32'h4) begin n_err++; $display("FAIL seq1 got %h exp 4", if_pc); end
        tick();
        n_cmp++; if (if_pc !== 32'h8 || if_instr !== 32'hA500_0008) begin n_err++; $display("FAIL seq2 got %h/%h exp 8/a5000008", if_pc, if_instr); end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (if_pc !== 32'h8 || if_instr !== 32'hA500_0008 || imem_addr !== 32'hC || if_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_hold%0d got pc=%h i=%h a=%h v=%b exp 8/a5000008/c/1", i, if_pc, if_instr, imem_addr, if_valid);
            end
        end
        stall = 0;
        tick();
        n_cmp++; if (if_pc !== 32'hC) begin n_err++; $display("FAIL stall_resume got %h exp c", if_pc); end
    endtask

    task automatic test_jr();
        jump = 2'b10; jr_addr = 32'h40;
        tick();
        n_cmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || imem_addr !== 32'h40) begin
            n_err++; $display("FAIL jr_bubble got v=%b i=%h a=%h exp 0/0/40", if_valid, if_instr, imem_addr);
        end
        clear_redirect();
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'hA500_0040) begin
            n_err++; $display("FAIL jr_target got v=%b pc=%h i=%h exp 1/40/a5000040", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_stall_redirect();
        stall = 1; branch_taken = 1; branch_target = 32'h20;
        tick();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h20) begin n_err++; $display("FAIL stbr_bubble got v=%b a=%h exp 0/20", if_valid, imem_addr); end
        clear_redirect();
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h20) begin n_err++; $display("FAIL stbr_target got v=%b pc=%h exp 1/20", if_valid, if_pc); end
    endtask

    task automatic test_ignore_invalid();
        jump = 2'b10; jr_addr = 32'h40;
        tick();
        jr_addr = 32'h80;
        tick();
        clear_redirect();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || imem_addr !== 32'h44) begin
            n_err++; $display("FAIL ignore got v=%b pc=%h a=%h exp 1/40/44", if_valid, if_pc, imem_addr);
        end
    endtask

    task automatic test_jump();
        jump = 2'b10; jr_addr = 32'hC;
        tick();
        clear_redirect();
        tick();
        n_cmp++; if (if_pc4 !== 32'h10) begin n_err++; $display("FAIL j_setup got %h exp 10", if_pc4); end
        jump = 2'b01; jump_index = 26'h3FF_FFFF;
        tick();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'hFC) begin n_err++; $display("FAIL j_bubble got v=%b a=%h exp 0/fc", if_valid, imem_addr); end
        clear_redirect();
        tick();
        n_cmp++; if (if_pc !== 32'h0FFF_FFFC || if_pc4 !== 32'h1000_0000 || if_instr !== 32'hA500_00FC) begin
            n_err++; $display("FAIL j_target got pc=%h p4=%h i=%h exp 0ffffffc/10000000/a50000fc", if_pc, if_pc4, if_instr);
        end
    endtask

    task automatic test_wrap();
        jump = 2'b10; jr_addr = 32'hFFFF_FFFC;
        tick();
        clear_redirect();
        tick();
        n_cmp++; if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL wrap got pc=%h p4=%h a=%h exp fffffffc/0/0", if_pc, if_pc4, imem_addr);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic        exp_exc;
        logic [31:0] exp_bad;
`ifdef IFETCH_MISALIGN_TRAP_EN
        exp_pc = 32'h80; exp_exc = 1'b1; exp_bad = 32'h22;
`else
        exp_pc = 32'h20; exp_exc = 1'b0; exp_bad = 32'h0;
`endif
        branch_taken = 1; branch_target = 32'h22;
        tick();
        clear_redirect();
        n_cmp++; if (fetch_exc !== exp_exc || bad_addr !== exp_bad || imem_addr !== exp_pc) begin
            n_err++; $display("FAIL mis_redir got e=%b b=%h a=%h exp %b/%h/%h", fetch_exc, bad_addr, imem_addr, exp_exc, exp_bad, exp_pc);
        end
        tick();
        n_cmp++; if (fetch_exc !== 1'b0 || if_pc !== exp_pc || if_valid !== 1'b1) begin
            n_err++; $display("FAIL mis_target got e=%b pc=%h v=%b exp 0/%h/1", fetch_exc, if_pc, if_valid, exp_pc);
        end
    endtask

    task automatic test_reset_mid();
        stall = 1;
        tick();
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || imem_addr !== 32'h0 || if_instr !== 32'h0) begin
            n_err++; $display("FAIL rst_mid got v=%b pc=%h a=%h i=%h exp 0/0/0/0", if_valid, if_pc, imem_addr, if_instr);
        end
        clear_redirect();
        tick();
        rst_n = 1;
        tick();
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_err++; $display("FAIL rst_restart got v=%b pc=%h exp 1/0", if_valid, if_pc); end
    endtask

    initial begin
        test_reset();
        test_boot_and_run();
        test_stall();
        test_jr();
        test_stall_redirect();
        test_ignore_invalid();
        test_jump();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the MIPS processor, directly upstream of the instruction memory and the decode/control logic. It owns the program counter, selects the next PC from sequential, branch and jump sources, drives the instruction-memory address, and latches the fetched word into an IF/ID register with valid, stall and flush control. It replaces the free-running testbench-driven PC and turns the single-cycle datapath into the front end of a pipelined one.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_BYTES, 256, instruction memory size in bytes; power of two
- EXC_VECTOR, 32'h0000_0080, fetch-exception handler address; used only with IFETCH_MISALIGN_TRAP_EN
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC and IF/ID contents
- branch_taken  in  1  branch resolved taken in decode
- branch_target  in  32  branch target byte address
- jump  in  2  00 none, 01 J/JAL (pseudo-direct), 10 JR (register), 11 reserved, treated as 00
- jump_index  in  26  instr[25:0] of the jump in decode
- jr_addr  in  32  register value for JR
- imem_addr  out  32  byte address to instruction memory, {0, pc[log2(IMEM_BYTES)-1:0]}
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- if_instr  out  32  latched instruction
- if_pc  out  32  PC of if_instr
- if_pc4  out  32  if_pc + 4
- if_valid  out  1  if_instr is a real instruction
- fetch_exc  out  1  one-cycle misaligned-redirect pulse
- bad_addr  out  32  offending target of the last fetch_exc

## Operation
- FSM states, ifetch_pkg::state_t: BOOT, RUN. Reset enters BOOT. On the first edge, BOOT moves to RUN with no capture and the PC held, giving one cycle of memory settle time. RUN never leaves except on reset.
- Redirect select, highest priority first: jump==10 uses jr_addr. jump==01 uses {pc_d4[31:28], jump_index, 2'b00}, where pc_d4 = if_pc4. branch_taken uses branch_target. Otherwise pc+4.
- Redirect is valid only when if_valid=1. Redirect inputs are ignored while if_valid=0.
- RUN, redirect: pc <= target. IF/ID is flushed: if_valid <= 0, if_instr <= 0. The wrong-path word at the old pc is discarded. A redirect overrides stall.
- RUN, stall, no redirect: pc and all IF/ID outputs hold.
- RUN, otherwise: pc <= pc+4. if_instr <= imem_rdata, if_pc <= pc, if_pc4 <= pc+4, if_valid <= 1.
- Arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- imem_addr truncates to the memory size: pc 32'h0000_0100 with IMEM_BYTES=256 addresses byte 0.

## Timing
- Reset values, asynchronous: pc=RESET_PC, if_instr=0, if_pc=0, if_pc4=0, if_valid=0, fetch_exc=0, bad_addr=0, state=BOOT.
- imem_addr is combinational from the pc register. It is valid in the same cycle and has zero latency to imem_rdata.
- First instruction: reset release, then edge 1 (BOOT→RUN), then edge 2 (if_valid=1, if_pc=RESET_PC).
- Fetch-to-IF/ID latency is one cycle. Steady-state throughput is one instruction per cycle.
- Redirect penalty is one bubble: one cycle with if_valid=0, then the target instruction.
- Reset asserted mid-stall or mid-redirect returns all state to the reset values immediately.

## Configuration
- IFETCH_MISALIGN_TRAP_EN defined: a redirect target with target[1:0]≠0 sets pc <= EXC_VECTOR, fetch_exc=1 for one cycle, and bad_addr <= target. IF/ID is flushed as for a normal redirect.
- IFETCH_MISALIGN_TRAP_EN undefined: target[1:0] is forced to 0. fetch_exc and bad_addr are tied to 0.

## Structure
- ifetch_pkg holds:
  - state_t {BOOT, RUN}
  - jump encodings JMP_NONE=2'b00, JMP_J=2'b01, JMP_JR=2'b10
  - the constant INSTR_BYTES=4
- One sub-module, ifetch_next_pc: a combinational priority mux producing next_pc and the misalign flag.

## Test plan
- Reset, then 4 free-running cycles -> if_pc sequence 0x0, 0x4, 0x8 with if_valid=1 starting on the 2nd edge; imem_addr=0x0 during BOOT.
- JR with jr_addr=0x40 while if_valid=1 -> next cycle if_valid=0; the following cycle if_pc=0x40.
- stall=1 for 3 cycles at if_pc=0x8 -> if_pc, if_instr and pc frozen; resumes with if_pc=0xC.
- stall=1 together with branch_taken=1 and branch_target=0x20 -> redirect wins, with a bubble and then if_pc=0x20.
- jump=01, jump_index=0x3FFFFFF, if_pc4=0x0000_0010 -> target 0x0FFF_FFFC; imem_addr=0xFC.
- branch_target=0x22 with IFETCH_MISALIGN_TRAP_EN -> fetch_exc pulse, bad_addr=0x22, next if_pc=0x80. Without the macro -> next if_pc=0x20.
